// File: rtl/clock_meter_mc.sv
// clock_meter_mc: multi-channel edge counter for frequency and event metering.
// Each asynchronous channel input is synchronised into clk_i and edge-detected.
// Edges are counted over a gate window of GATE_CYCLES clock cycles.
// Per-channel results, saturation and stuck flags are published together
// with a single-cycle valid strobe, and they hold until the next window ends.

module clock_meter_mc #(
    parameter int CH_NUM      = 4,
    parameter int CNT_WIDTH   = 32,
    parameter int GATE_CYCLES = 100000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk_i,
    input  logic                          a_rst_n_i,
    input  logic                          start_i,
    input  logic                          cont_i,
    input  logic [CH_NUM-1:0]             edge_both_i,
    input  logic [CH_NUM-1:0]             msr_i,
    output logic                          busy_o,
    output logic                          msr_vld_o,
    output logic [CH_NUM*CNT_WIDTH-1:0]   msr_val_o,
    output logic [CH_NUM-1:0]             ovf_o,
    output logic [CH_NUM-1:0]             stuck_o
);

    localparam int                    GATE_W    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0]     GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

    typedef enum logic {
        ST_IDLE,
        ST_GATE
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;

    logic [CH_NUM-1:0]      r_sync [SYNC_STAGES];
    logic [CH_NUM-1:0]      r_prev;
    logic [CH_NUM-1:0]      w_syncOut;
    logic [CH_NUM-1:0]      w_rise;
    logic [CH_NUM-1:0]      w_edge;

    logic [GATE_W-1:0]      r_gateCnt;
    logic                   w_startWin;
    logic                   w_winEnd;

    logic [CNT_WIDTH-1:0]   r_cnt     [CH_NUM];
    logic [CNT_WIDTH:0]     w_sum     [CH_NUM];
    logic [CNT_WIDTH-1:0]   w_cntNext [CH_NUM];
    logic [CH_NUM-1:0]      w_hit;
    logic [CH_NUM-1:0]      w_zero;
    logic [CH_NUM-1:0]      r_ovfSt;

    logic                   r_msrVld;
    logic [CH_NUM*CNT_WIDTH-1:0] r_msrVal;
    logic [CH_NUM-1:0]      r_ovf;
    logic [CH_NUM-1:0]      r_stuck;

    // Synchroniser chain per channel plus one extra stage used for edge detection
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= msr_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Edge pulse: rising always, falling too on channels configured for both edges
    always_comb begin
        w_syncOut = r_sync[SYNC_STAGES-1];
        w_rise    = w_syncOut & ~r_prev;
        w_edge    = w_rise | (edge_both_i & (w_syncOut ^ r_prev));
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: start only from IDLE, leave GATE at window end unless continuous
    always_comb begin
        w_nextState = r_state;
        w_startWin  = 1'b0;
        w_winEnd    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_startWin  = 1'b1;
                    w_nextState = ST_GATE;
                end
            end
            ST_GATE: begin
                if (r_gateCnt == GATE_LAST) begin
                    w_winEnd = 1'b1;
                    if (!cont_i) begin
                        w_nextState = ST_IDLE;
                    end
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Saturating next count per channel; the final-cycle edge is folded into the result
    always_comb begin
        w_hit  = '0;
        w_zero = '0;
        for (int n = 0; n < CH_NUM; n++) begin
            w_sum[n]     = {1'b0, r_cnt[n]} + {{CNT_WIDTH{1'b0}}, w_edge[n]};
            w_cntNext[n] = w_sum[n][CNT_WIDTH-1:0];
            if (w_sum[n] >= {1'b0, CNT_MAX}) begin
                w_cntNext[n] = CNT_MAX;
                w_hit[n]     = 1'b1;
            end
            w_zero[n] = (w_cntNext[n] == '0);
        end
    end

    // Gate counter, channel counters and result publication
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            r_gateCnt <= '0;
            for (int n = 0; n < CH_NUM; n++) begin
                r_cnt[n] <= '0;
            end
            r_ovfSt  <= '0;
            r_msrVld <= 1'b0;
            r_msrVal <= '0;
            r_ovf    <= '0;
            r_stuck  <= '0;
        end else begin
            r_msrVld <= 1'b0;
            if (w_startWin) begin
                r_gateCnt <= '0;
                for (int n = 0; n < CH_NUM; n++) begin
                    r_cnt[n] <= '0;
                end
                r_ovfSt <= '0;
            end else if (r_state == ST_GATE) begin
                if (w_winEnd) begin
                    r_gateCnt <= '0;
                    for (int n = 0; n < CH_NUM; n++) begin
                        r_msrVal[n*CNT_WIDTH +: CNT_WIDTH] <= w_cntNext[n];
                        r_cnt[n] <= '0;
                    end
                    r_ovf    <= r_ovfSt | w_hit;
                    r_stuck  <= w_zero;
                    r_ovfSt  <= '0;
                    r_msrVld <= 1'b1;
                end else begin
                    r_gateCnt <= r_gateCnt + GATE_W'(1);
                    for (int n = 0; n < CH_NUM; n++) begin
                        r_cnt[n] <= w_cntNext[n];
                    end
                    r_ovfSt <= r_ovfSt | w_hit;
                end
            end
        end
    end

    assign busy_o    = (r_state == ST_GATE);
    assign msr_vld_o = r_msrVld;
    assign msr_val_o = r_msrVal;
    assign ovf_o     = r_ovf;
    assign stuck_o   = r_stuck;

endmodule

// File: tb/tb_clock_meter_mc.sv
// tb_clock_meter_mc: randomized self-checking bench for clock_meter_mc.
// Two instances share all inputs: an 8-bit and a 4-bit counter version,
// so saturation is exercised alongside normal counting.
// Expected results come from a history of the sampled inputs: every
// qualifying transition is counted into the window it falls in.

module tb_clock_meter_mc;

    localparam int CH   = 4;
    localparam int G    = 100;
    localparam int S    = 2;
    localparam int WW   = 8;
    localparam int NW   = 4;
    localparam int HIST = 8192;

    logic                clk = 1'b0;
    logic                rstN;
    logic                start;
    logic                cont;
    logic [CH-1:0]       edgeBoth;
    logic [CH-1:0]       msr;

    logic                busyW, vldW, busyN, vldN;
    logic [CH*WW-1:0]    valW;
    logic [CH*NW-1:0]    valN;
    logic [CH-1:0]       ovfW, stuckW, ovfN, stuckN;

    int                  cyc = 0;
    logic [CH-1:0]       hist [HIST];
    int                  chPeriod [CH];
    int                  chPhase  [CH];
    logic                chLevel  [CH];
    int                  expQ [$];
    int                  checks = 0;
    int                  errors = 0;
    bit                  contRange = 1'b0;

    clock_meter_mc #(
        .CH_NUM(CH), .CNT_WIDTH(WW), .GATE_CYCLES(G), .SYNC_STAGES(S)
    ) dut (
        .clk_i(clk), .a_rst_n_i(rstN), .start_i(start), .cont_i(cont),
        .edge_both_i(edgeBoth), .msr_i(msr), .busy_o(busyW), .msr_vld_o(vldW),
        .msr_val_o(valW), .ovf_o(ovfW), .stuck_o(stuckW)
    );

    clock_meter_mc #(
        .CH_NUM(CH), .CNT_WIDTH(NW), .GATE_CYCLES(G), .SYNC_STAGES(S)
    ) dutNarrow (
        .clk_i(clk), .a_rst_n_i(rstN), .start_i(start), .cont_i(cont),
        .edge_both_i(edgeBoth), .msr_i(msr), .busy_o(busyN), .msr_vld_o(vldN),
        .msr_val_o(valN), .ovf_o(ovfN), .stuck_o(stuckN)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0d expected=%0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Edges of channel n counted in the window whose last clock edge is endCyc
    function automatic int modelCount(input int endCyc, input int n);
        int c = 0;
        for (int k = endCyc - G + 1 - S; k <= endCyc - S; k++) begin
            if (k >= 1 && k < HIST) begin
                if (hist[k][n] && !hist[k-1][n]) c++;
                else if (edgeBoth[n] && !hist[k][n] && hist[k-1][n]) c++;
            end
        end
        return c;
    endfunction

    // Record the input value each clock edge actually samples (zero while in reset)
    initial begin
        for (int i = 0; i < HIST; i++) hist[i] = '0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (cyc < HIST) hist[cyc] = rstN ? msr : '0;
        end
    end

    // Drive the measured signals away from the active edge: square waves or held levels
    initial begin
        msr = '0;
        forever begin
            @(negedge clk);
            for (int n = 0; n < CH; n++) begin
                if (chPeriod[n] == 0) msr[n] = chLevel[n];
                else msr[n] = (((cyc + chPhase[n]) % chPeriod[n]) < (chPeriod[n] / 2));
            end
        end
    end

    // Watch for strobes: each must land exactly on an expected window end with model results
    initial begin
        forever begin
            @(negedge clk);
            if (rstN) begin
                automatic bit due = (expQ.size() > 0) && (expQ[0] == cyc);
                if (vldW || vldN || due) begin
                    checkOutput("vldWide", 32'(vldW), 32'(due));
                    checkOutput("vldNarrow", 32'(vldN), 32'(due));
                    if (due) begin
                        void'(expQ.pop_front());
                        for (int n = 0; n < CH; n++) begin
                            automatic int c  = modelCount(cyc, n);
                            automatic int ew = (c > 255) ? 255 : c;
                            automatic int en = (c > 15) ? 15 : c;
                            checkOutput($sformatf("valWide%0d", n), 32'(valW[n*WW +: WW]), 32'(ew));
                            checkOutput($sformatf("ovfWide%0d", n), 32'(ovfW[n]), 32'(c >= 255));
                            checkOutput($sformatf("stuckWide%0d", n), 32'(stuckW[n]), 32'(c == 0));
                            checkOutput($sformatf("valNarrow%0d", n), 32'(valN[n*NW +: NW]), 32'(en));
                            checkOutput($sformatf("ovfNarrow%0d", n), 32'(ovfN[n]), 32'(c >= 15));
                            checkOutput($sformatf("stuckNarrow%0d", n), 32'(stuckN[n]), 32'(c == 0));
                        end
                        if (contRange) begin
                            checkOutput("contRange0", 32'((valW[WW-1:0] == 8'd14) || (valW[WW-1:0] == 8'd15)), 32'd1);
                        end
                    end
                end
            end
        end
    end

    // Run nWin windows (continuous when nWin > 1), optionally holding start through the gate
    task automatic applyStimulus(input int nWin, input bit holdStart);
        int t0;
        int budget = 0;
        @(negedge clk);
        start = 1'b1;
        cont  = (nWin > 1);
        t0    = cyc + 1;
        for (int i = 1; i <= nWin; i++) expQ.push_back(t0 + i * G);
        @(negedge clk);
        checkOutput("busyAfterStart", 32'(busyW), 32'd1);
        if (!holdStart) start = 1'b0;
        while (expQ.size() > 0 && budget < nWin * G + 50) begin
            @(negedge clk);
            budget++;
            if (holdStart && cyc >= t0 + G - 5) start = 1'b0;
            if (nWin > 1 && cyc >= t0 + (nWin - 1) * G + 10) cont = 1'b0;
        end
        if (expQ.size() > 0) begin
            checkOutput("vldTimeout", 32'(expQ.size()), 32'd0);
            expQ.delete();
        end
        start = 1'b0;
        cont  = 1'b0;
        checkOutput("busyIdle", 32'(busyW), 32'd0);
    endtask

    task automatic setChannel(input int n, input int period, input int phase, input logic level);
        chPeriod[n] = period;
        chPhase[n]  = phase;
        chLevel[n]  = level;
    endtask

    // Main sequence: reset, directed scenarios, then randomized windows
    initial begin
        rstN     = 1'b0;
        start    = 1'b0;
        cont     = 1'b0;
        edgeBoth = '0;
        for (int n = 0; n < CH; n++) setChannel(n, 0, 0, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("rstBusy", 32'(busyW), 32'd0);
        checkOutput("rstVld", 32'(vldW), 32'd0);
        checkOutput("rstVal", valW, 32'd0);
        checkOutput("rstFlags", {24'd0, ovfW, stuckW}, 32'd0);
        rstN = 1'b1;
        repeat (5) @(negedge clk);

        // Basic window: rising, both-edge, held-low and held-high channels
        setChannel(0, 10, 3, 1'b0);
        setChannel(1, 10, 3, 1'b0);
        setChannel(2, 0, 0, 1'b0);
        setChannel(3, 0, 0, 1'b1);
        edgeBoth = 4'b0010;
        repeat (10) @(negedge clk);
        applyStimulus(1, 1'b0);
        checkOutput("basicVal0", 32'(valW[7:0]), 32'd10);
        checkOutput("basicOvf0", 32'(ovfW[0]), 32'd0);
        checkOutput("basicStuck0", 32'(stuckW[0]), 32'd0);
        checkOutput("basicVal1", 32'(valW[15:8]), 32'd20);
        checkOutput("basicVal2", 32'(valW[23:16]), 32'd0);
        checkOutput("basicStuck2", 32'(stuckW[2]), 32'd1);
        checkOutput("basicVal3", 32'(valW[31:24]), 32'd0);
        checkOutput("basicStuck3", 32'(stuckW[3]), 32'd1);

        // Saturation on the narrow instance, then recovery on the next window
        edgeBoth = '0;
        setChannel(0, 4, 1, 1'b0);
        repeat (10) @(negedge clk);
        applyStimulus(1, 1'b0);
        checkOutput("satNarrowVal0", 32'(valN[3:0]), 32'd15);
        checkOutput("satNarrowOvf0", 32'(ovfN[0]), 32'd1);
        checkOutput("satWideVal0", 32'(valW[7:0]), 32'd25);
        setChannel(0, 10, 0, 1'b0);
        repeat (10) @(negedge clk);
        applyStimulus(1, 1'b0);
        checkOutput("recoverNarrowVal0", 32'(valN[3:0]), 32'd10);
        checkOutput("recoverNarrowOvf0", 32'(ovfN[0]), 32'd0);

        // Continuous back-to-back windows with a period-7 signal at random phase
        setChannel(0, 7, $urandom_range(0, 6), 1'b0);
        contRange = 1'b1;
        applyStimulus(5, 1'b0);
        contRange = 1'b0;

        // Start held through the gate must not restart; a later pulse starts a new window
        setChannel(0, 10, 0, 1'b0);
        repeat (5) @(negedge clk);
        applyStimulus(1, 1'b1);
        repeat (5) @(negedge clk);
        applyStimulus(1, 1'b0);

        // Reset in the middle of a window: outputs clear at once and the window is dropped
        begin
            int t0;
            @(negedge clk);
            start = 1'b1;
            t0    = cyc + 1;
            @(negedge clk);
            start = 1'b0;
            while (cyc < t0 + 50) @(negedge clk);
            #2 rstN = 1'b0;
            expQ.delete();
            #1;
            checkOutput("midRstBusy", 32'(busyW), 32'd0);
            checkOutput("midRstVal", valW, 32'd0);
            checkOutput("midRstNarrowVal", 32'(valN), 32'd0);
            checkOutput("midRstFlags", {24'd0, ovfW, stuckW}, 32'd0);
            repeat (4) @(negedge clk);
            rstN = 1'b1;
            repeat (G + 10) @(negedge clk);
            applyStimulus(1, 1'b0);
            checkOutput("postRstVal0", 32'(valW[7:0]), 32'd10);
        end

        // Randomized windows: random periods, levels, edge modes and window counts
        repeat (6) begin
            for (int n = 0; n < CH; n++) begin
                if ($urandom_range(0, 5) == 0) setChannel(n, 0, 0, 1'($urandom_range(0, 1)));
                else setChannel(n, $urandom_range(3, 24), $urandom_range(0, 23), 1'b0);
            end
            edgeBoth = 4'($urandom);
            repeat (5) @(negedge clk);
            applyStimulus($urandom_range(1, 3), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
